ctrl_pipeline: RTL and testbench
================================

# ctrl_pipeline

Parametrised control pipeline for the 5-stage RV32I core: it carries decoded control fields from Decode through Execute, Memory and Writeback, evaluates the full RV32I branch-condition set, and integrates hazard detection (load-use stall, branch flush, forwarding selects) with a whole-pipeline freeze for a slow data memory. It sits between the instruction decoder and the data path, replacing the fixed-width, stall-less control path and the standalone hazard unit.

## Interface
- ALU_CTRL_W, 4, width of ALU control field
- RESULT_SRC_W, 2, width of result-select field (value 1 = load data)
- REG_ADDR_W, 5, register index width

- i_Clk  in  1  clock
- i_Reset  in  1  reset; one clock, synchronous, active-high
- i_ValidD  in  1  Decode slot holds a real instruction
- i_RegWriteD, i_MemWriteD, i_JumpD, i_BranchD, i_ALUSrcD  in  1 each  decoded controls
- i_ResultSrcD  in  RESULT_SRC_W  result select
- i_ALUControlD  in  ALU_CTRL_W  ALU operation
- i_BranchTypeD  in  3  funct3 of branch
- i_Rs1D, i_Rs2D, i_RdD  in  REG_ADDR_W  register indices
- i_ZeroE, i_LtE, i_LtuE  in  1 each  ALU flags: equal, signed less-than, unsigned less-than
- i_MemStall  in  1  data memory not ready; freeze
- o_ALUControlE  out  ALU_CTRL_W;  o_ALUSrcE  out  1
- o_PCSrcE  out  1  redirect fetch to branch/jump target
- o_MemWriteM  out  1
- o_RegWriteW  out  1;  o_ResultSrcW  out  RESULT_SRC_W
- o_StallF, o_StallD, o_FlushD, o_FlushE  out  1 each  data-path pipeline register controls
- o_ForwardAE, o_ForwardBE  out  2 each  00 register file, 01 from W, 10 from M

## Operation
- Stage registers E, M, W each hold: Valid, RegWrite, ResultSrc, MemWrite, Rd; E also holds Jump, Branch, BranchType, ALUControl, ALUSrc, Rs1, Rs2.
- Register update priority per cycle: i_Reset (all fields 0) > i_MemStall (E, M, W all hold) > FlushE (E loads all-zero bubble; M, W advance normally) > normal advance.
- Branch condition from E.BranchType: 000 Zero; 001 !Zero; 100 Lt; 101 !Lt; 110 Ltu; 111 !Ltu; 010/011 false.
- o_PCSrcE = ValidE & (JumpE | (BranchE & cond)).
- lwStall = ValidE & RegWriteE & (ResultSrcE == 1) & (RdE != 0) & (RdE == i_Rs1D | RdE == i_Rs2D).
- o_StallF = o_StallD = lwStall | i_MemStall.
- o_FlushE = (lwStall | o_PCSrcE) & ~i_MemStall; o_FlushD = o_PCSrcE & ~i_MemStall.
- Forward A: 10 if ValidM & RegWriteM & RdM != 0 & RdM == Rs1E; else 01 if same test on W; else 00. M has priority over W. Forward B identical on Rs2E.
- Index 0 never forwards and never triggers lwStall.
- Outputs gated by Valid: o_MemWriteM = ValidM & MemWriteM; o_RegWriteW = ValidW & RegWriteW. ResultSrcW and ALU fields pass unmodified.

## Timing
- Decode-to-Execute latency 1 clock, to Memory 2, to Writeback 3 (absent stalls).
- Registered outputs: o_ALUControlE, o_ALUSrcE, o_MemWriteM, o_RegWriteW, o_ResultSrcW; all 0 after reset.
- Combinational outputs: o_PCSrcE, stall/flush, forward selects; with all stage registers reset they evaluate to 0 (forward 00).
- Load-use: one bubble inserted; the dependent instruction enters E one cycle late and receives ForwardXE = 01 (load now in W).
- Taken branch/jump in E: the two younger instructions (D and E-bound) are squashed in the same edge; fetch redirects next cycle.
- Simultaneous lwStall and o_PCSrcE: FlushE and FlushD both asserted; branch wins, stall is harmless.
- i_MemStall held N cycles: all stage registers frozen N cycles, no flush applied, combinational outputs stable; resumes exactly where it stopped.
- Reset asserted mid-stream: next edge clears all stages regardless of i_MemStall.

## Test plan
- Reset: assert i_Reset 2 cycles with random inputs -> all registered outputs 0, o_PCSrcE 0, forwards 00.
- ALU chain: add x5 then sub using x5 back-to-back -> o_ForwardAE = 10 in cycle 2; with one unrelated instruction between -> 01; with Rd = x0 -> 00.
- Load-use: lw x6 followed by add x7,x6,x1 -> o_StallF/o_StallD/o_FlushE high exactly 1 cycle, then o_ForwardAE = 01.
- Branches: each funct3 with flag combinations (e.g. BLTU, i_LtuE=1 -> o_PCSrcE 1; BGE, i_LtE=1 -> 0; funct3 010 -> 0) -> o_FlushD and o_FlushE high that cycle, next E slot invalid (o_MemWriteM stays 0 two cycles later for a squashed sw).
- Memory stall: i_MemStall high 3 cycles while a sw sits in M -> o_MemWriteM stays 1 throughout, stage contents unchanged, no flush even with a taken branch in E; branch flush takes effect on first unstalled cycle.
- Reset mid-stall: i_Reset and i_MemStall together -> all stages 0 next edge.

Source files
------------

// File: rtl/ctrl_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipeline
// Brief    : RV32I control pipeline (D->E->M->W) with branch resolution,
//            load-use stall, branch flush, forwarding and memory-stall freeze.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipeline #(
    parameter int ALU_CTRL_W   = 4,
    parameter int RESULT_SRC_W = 2,
    parameter int REG_ADDR_W   = 5
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic                    i_ValidD,
    input  logic                    i_RegWriteD,
    input  logic                    i_MemWriteD,
    input  logic                    i_JumpD,
    input  logic                    i_BranchD,
    input  logic                    i_ALUSrcD,
    input  logic [RESULT_SRC_W-1:0] i_ResultSrcD,
    input  logic [ALU_CTRL_W-1:0]   i_ALUControlD,
    input  logic [2:0]              i_BranchTypeD,
    input  logic [REG_ADDR_W-1:0]   i_Rs1D,
    input  logic [REG_ADDR_W-1:0]   i_Rs2D,
    input  logic [REG_ADDR_W-1:0]   i_RdD,
    input  logic                    i_ZeroE,
    input  logic                    i_LtE,
    input  logic                    i_LtuE,
    input  logic                    i_MemStall,
    output logic [ALU_CTRL_W-1:0]   o_ALUControlE,
    output logic                    o_ALUSrcE,
    output logic                    o_PCSrcE,
    output logic                    o_MemWriteM,
    output logic                    o_RegWriteW,
    output logic [RESULT_SRC_W-1:0] o_ResultSrcW,
    output logic                    o_StallF,
    output logic                    o_StallD,
    output logic                    o_FlushD,
    output logic                    o_FlushE,
    output logic [1:0]              o_ForwardAE,
    output logic [1:0]              o_ForwardBE
);

    localparam logic [2:0] c_BR_EQ  = 3'b000;
    localparam logic [2:0] c_BR_NE  = 3'b001;
    localparam logic [2:0] c_BR_LT  = 3'b100;
    localparam logic [2:0] c_BR_GE  = 3'b101;
    localparam logic [2:0] c_BR_LTU = 3'b110;
    localparam logic [2:0] c_BR_GEU = 3'b111;

    localparam logic [1:0] c_FWD_RF = 2'b00;
    localparam logic [1:0] c_FWD_W  = 2'b01;
    localparam logic [1:0] c_FWD_M  = 2'b10;

    localparam logic [RESULT_SRC_W-1:0] c_RES_LOAD = RESULT_SRC_W'(1);
    localparam logic [REG_ADDR_W-1:0]   c_REG_X0   = '0;

    typedef struct packed {
        logic                    valid;
        logic                    reg_write;
        logic [RESULT_SRC_W-1:0] result_src;
        logic                    mem_write;
        logic [REG_ADDR_W-1:0]   rd;
        logic                    jump;
        logic                    branch;
        logic [2:0]              branch_type;
        logic [ALU_CTRL_W-1:0]   alu_control;
        logic                    alu_src;
        logic [REG_ADDR_W-1:0]   rs1;
        logic [REG_ADDR_W-1:0]   rs2;
    } ex_stage_t;

    typedef struct packed {
        logic                    valid;
        logic                    reg_write;
        logic [RESULT_SRC_W-1:0] result_src;
        logic                    mem_write;
        logic [REG_ADDR_W-1:0]   rd;
    } mem_stage_t;

    // Store flag is consumed in M; W keeps only what writeback and forwarding need.
    typedef struct packed {
        logic                    valid;
        logic                    reg_write;
        logic [RESULT_SRC_W-1:0] result_src;
        logic [REG_ADDR_W-1:0]   rd;
    } wb_stage_t;

    ex_stage_t  r_ex_q;
    ex_stage_t  w_ex_d;
    ex_stage_t  w_ex_dec;
    mem_stage_t r_mem_q;
    mem_stage_t w_mem_d;
    wb_stage_t  r_wb_q;
    wb_stage_t  w_wb_d;

    logic w_branch_cond;
    logic w_pc_src;
    logic w_lw_stall;
    logic w_flush_e;
    logic w_flush_d;

    function automatic logic [1:0] fwd_sel(
        input logic                  m_valid,
        input logic                  m_reg_write,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  w_valid,
        input logic                  w_reg_write,
        input logic [REG_ADDR_W-1:0] w_rd,
        input logic [REG_ADDR_W-1:0] rs
    );
        logic [1:0] sel;
        sel = c_FWD_RF;
        if (m_valid && m_reg_write && (m_rd != c_REG_X0) && (m_rd == rs)) begin
            sel = c_FWD_M;
        end else if (w_valid && w_reg_write && (w_rd != c_REG_X0) && (w_rd == rs)) begin
            sel = c_FWD_W;
        end
        return sel;
    endfunction

    always_comb begin
        w_ex_dec             = '0;
        w_ex_dec.valid       = i_ValidD;
        w_ex_dec.reg_write   = i_RegWriteD;
        w_ex_dec.result_src  = i_ResultSrcD;
        w_ex_dec.mem_write   = i_MemWriteD;
        w_ex_dec.rd          = i_RdD;
        w_ex_dec.jump        = i_JumpD;
        w_ex_dec.branch      = i_BranchD;
        w_ex_dec.branch_type = i_BranchTypeD;
        w_ex_dec.alu_control = i_ALUControlD;
        w_ex_dec.alu_src     = i_ALUSrcD;
        w_ex_dec.rs1         = i_Rs1D;
        w_ex_dec.rs2         = i_Rs2D;
    end

    always_comb begin
        w_branch_cond = 1'b0;
        case (r_ex_q.branch_type)
            c_BR_EQ:  w_branch_cond = i_ZeroE;
            c_BR_NE:  w_branch_cond = ~i_ZeroE;
            c_BR_LT:  w_branch_cond = i_LtE;
            c_BR_GE:  w_branch_cond = ~i_LtE;
            c_BR_LTU: w_branch_cond = i_LtuE;
            c_BR_GEU: w_branch_cond = ~i_LtuE;
            default:  w_branch_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_pc_src   = r_ex_q.valid & (r_ex_q.jump | (r_ex_q.branch & w_branch_cond));
        w_lw_stall = r_ex_q.valid & r_ex_q.reg_write
                   & (r_ex_q.result_src == c_RES_LOAD)
                   & (r_ex_q.rd != c_REG_X0)
                   & ((r_ex_q.rd == i_Rs1D) | (r_ex_q.rd == i_Rs2D));
        // A frozen pipeline must not lose the instructions a flush would kill.
        w_flush_e  = (w_lw_stall | w_pc_src) & ~i_MemStall;
        w_flush_d  = w_pc_src & ~i_MemStall;
    end

    always_comb begin
        w_ex_d  = r_ex_q;
        w_mem_d = r_mem_q;
        w_wb_d  = r_wb_q;
        if (!i_MemStall) begin
            w_mem_d.valid      = r_ex_q.valid;
            w_mem_d.reg_write  = r_ex_q.reg_write;
            w_mem_d.result_src = r_ex_q.result_src;
            w_mem_d.mem_write  = r_ex_q.mem_write;
            w_mem_d.rd         = r_ex_q.rd;
            w_wb_d.valid       = r_mem_q.valid;
            w_wb_d.reg_write   = r_mem_q.reg_write;
            w_wb_d.result_src  = r_mem_q.result_src;
            w_wb_d.rd          = r_mem_q.rd;
            w_ex_d             = w_flush_e ? ex_stage_t'('0) : w_ex_dec;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_ex_q  <= '0;
            r_mem_q <= '0;
            r_wb_q  <= '0;
        end else begin
            r_ex_q  <= w_ex_d;
            r_mem_q <= w_mem_d;
            r_wb_q  <= w_wb_d;
        end
    end

    always_comb begin
        o_ForwardAE = fwd_sel(r_mem_q.valid, r_mem_q.reg_write, r_mem_q.rd,
                              r_wb_q.valid, r_wb_q.reg_write, r_wb_q.rd, r_ex_q.rs1);
        o_ForwardBE = fwd_sel(r_mem_q.valid, r_mem_q.reg_write, r_mem_q.rd,
                              r_wb_q.valid, r_wb_q.reg_write, r_wb_q.rd, r_ex_q.rs2);
    end

    assign o_ALUControlE = r_ex_q.alu_control;
    assign o_ALUSrcE     = r_ex_q.alu_src;
    assign o_PCSrcE      = w_pc_src;
    assign o_MemWriteM   = r_mem_q.valid & r_mem_q.mem_write;
    assign o_RegWriteW   = r_wb_q.valid & r_wb_q.reg_write;
    assign o_ResultSrcW  = r_wb_q.result_src;
    assign o_StallF      = w_lw_stall | i_MemStall;
    assign o_StallD      = w_lw_stall | i_MemStall;
    assign o_FlushD      = w_flush_d;
    assign o_FlushE      = w_flush_e;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipeline
// Brief    : Directed self-checking bench for ctrl_pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipeline;

    logic       i_Clk;
    logic       i_Reset;
    logic       i_ValidD, i_RegWriteD, i_MemWriteD, i_JumpD, i_BranchD, i_ALUSrcD;
    logic [1:0] i_ResultSrcD;
    logic [3:0] i_ALUControlD;
    logic [2:0] i_BranchTypeD;
    logic [4:0] i_Rs1D, i_Rs2D, i_RdD;
    logic       i_ZeroE, i_LtE, i_LtuE, i_MemStall;
    logic [3:0] o_ALUControlE;
    logic       o_ALUSrcE, o_PCSrcE, o_MemWriteM, o_RegWriteW;
    logic [1:0] o_ResultSrcW;
    logic       o_StallF, o_StallD, o_FlushD, o_FlushE;
    logic [1:0] o_ForwardAE, o_ForwardBE;

    int total = 0;
    int bad   = 0;

    ctrl_pipeline #(.ALU_CTRL_W(4), .RESULT_SRC_W(2), .REG_ADDR_W(5)) u_dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_ValidD(i_ValidD),
        .i_RegWriteD(i_RegWriteD), .i_MemWriteD(i_MemWriteD), .i_JumpD(i_JumpD),
        .i_BranchD(i_BranchD), .i_ALUSrcD(i_ALUSrcD), .i_ResultSrcD(i_ResultSrcD),
        .i_ALUControlD(i_ALUControlD), .i_BranchTypeD(i_BranchTypeD),
        .i_Rs1D(i_Rs1D), .i_Rs2D(i_Rs2D), .i_RdD(i_RdD),
        .i_ZeroE(i_ZeroE), .i_LtE(i_LtE), .i_LtuE(i_LtuE), .i_MemStall(i_MemStall),
        .o_ALUControlE(o_ALUControlE), .o_ALUSrcE(o_ALUSrcE), .o_PCSrcE(o_PCSrcE),
        .o_MemWriteM(o_MemWriteM), .o_RegWriteW(o_RegWriteW), .o_ResultSrcW(o_ResultSrcW),
        .o_StallF(o_StallF), .o_StallD(o_StallD), .o_FlushD(o_FlushD), .o_FlushE(o_FlushE),
        .o_ForwardAE(o_ForwardAE), .o_ForwardBE(o_ForwardBE)
    );

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge i_Clk);
        #1;
    endtask

    task automatic clear_d;
        i_ValidD = 0; i_RegWriteD = 0; i_MemWriteD = 0; i_JumpD = 0; i_BranchD = 0;
        i_ALUSrcD = 0; i_ResultSrcD = 0; i_ALUControlD = 0; i_BranchTypeD = 0;
        i_Rs1D = 0; i_Rs2D = 0; i_RdD = 0; i_ZeroE = 0; i_LtE = 0; i_LtuE = 0;
    endtask

    // Fields: regwrite, resultsrc, memwrite, jump, branch, btype, alu, rs1, rs2, rd
    task automatic drive_d(input logic rw, input logic [1:0] rs, input logic mw,
                           input logic j, input logic br, input logic [2:0] bt,
                           input logic [3:0] alu, input logic [4:0] r1,
                           input logic [4:0] r2, input logic [4:0] rd);
        i_ValidD = 1; i_RegWriteD = rw; i_ResultSrcD = rs; i_MemWriteD = mw;
        i_JumpD = j; i_BranchD = br; i_BranchTypeD = bt; i_ALUControlD = alu;
        i_ALUSrcD = 0; i_Rs1D = r1; i_Rs2D = r2; i_RdD = rd;
    endtask

    task automatic drain;
        clear_d();
        i_MemStall = 0;
        repeat (3) tick();
    endtask

    task automatic test_reset;
        i_Reset = 1;
        repeat (2) begin
            i_ValidD = 1'($urandom); i_RegWriteD = 1'($urandom); i_MemWriteD = 1'($urandom);
            i_JumpD = 1'($urandom); i_BranchD = 1'($urandom); i_ALUSrcD = 1'($urandom);
            i_ResultSrcD = 2'($urandom); i_ALUControlD = 4'($urandom);
            i_BranchTypeD = 3'($urandom); i_Rs1D = 5'($urandom); i_Rs2D = 5'($urandom);
            i_RdD = 5'($urandom); i_ZeroE = 1'($urandom); i_LtE = 1'($urandom);
            i_LtuE = 1'($urandom); i_MemStall = 1'($urandom);
            tick();
        end
        total++; if (o_ALUControlE !== 4'd0) begin bad++; $display("FAIL reset_alu: got %0h expected 0", o_ALUControlE); end
        total++; if (o_ALUSrcE !== 1'b0) begin bad++; $display("FAIL reset_alusrc: got %0b expected 0", o_ALUSrcE); end
        total++; if (o_MemWriteM !== 1'b0) begin bad++; $display("FAIL reset_memwrite: got %0b expected 0", o_MemWriteM); end
        total++; if (o_RegWriteW !== 1'b0) begin bad++; $display("FAIL reset_regwrite: got %0b expected 0", o_RegWriteW); end
        total++; if (o_ResultSrcW !== 2'd0) begin bad++; $display("FAIL reset_resultsrc: got %0d expected 0", o_ResultSrcW); end
        total++; if (o_PCSrcE !== 1'b0) begin bad++; $display("FAIL reset_pcsrc: got %0b expected 0", o_PCSrcE); end
        total++; if (o_FlushD !== 1'b0) begin bad++; $display("FAIL reset_flushd: got %0b expected 0", o_FlushD); end
        total++; if (o_ForwardAE !== 2'b00 || o_ForwardBE !== 2'b00) begin
            bad++; $display("FAIL reset_fwd: got A=%0b B=%0b expected 00/00", o_ForwardAE, o_ForwardBE); end
        i_Reset = 0;
        drain();
    endtask

    task automatic test_alu_chain;
        // Back-to-back dependency: forward from M.
        drive_d(1, 0, 0, 0, 0, 0, 4'h0, 5'd1, 5'd2, 5'd5); tick();
        drive_d(1, 0, 0, 0, 0, 0, 4'h8, 5'd5, 5'd3, 5'd8); tick();
        total++; if (o_ForwardAE !== 2'b10) begin bad++; $display("FAIL chain_m_fwdA: got %0b expected 10", o_ForwardAE); end
        total++; if (o_ForwardBE !== 2'b00) begin bad++; $display("FAIL chain_m_fwdB: got %0b expected 00", o_ForwardBE); end
        total++; if (o_ALUControlE !== 4'h8) begin bad++; $display("FAIL chain_alu: got %0h expected 8", o_ALUControlE); end
        drain();
        // One unrelated instruction between: forward from W on operand B.
        drive_d(1, 0, 0, 0, 0, 0, 4'h0, 5'd1, 5'd2, 5'd5); tick();
        drive_d(1, 0, 0, 0, 0, 0, 4'h0, 5'd1, 5'd2, 5'd9); tick();
        drive_d(1, 0, 0, 0, 0, 0, 4'h8, 5'd3, 5'd5, 5'd8); tick();
        total++; if (o_ForwardBE !== 2'b01) begin bad++; $display("FAIL chain_w_fwdB: got %0b expected 01", o_ForwardBE); end
        total++; if (o_ForwardAE !== 2'b00) begin bad++; $display("FAIL chain_w_fwdA: got %0b expected 00", o_ForwardAE); end
        total++; if (o_RegWriteW !== 1'b1) begin bad++; $display("FAIL chain_regwrite_w: got %0b expected 1", o_RegWriteW); end
        drain();
        // x0 destination never forwards.
        drive_d(1, 0, 0, 0, 0, 0, 4'h0, 5'd1, 5'd2, 5'd0); tick();
        drive_d(1, 0, 0, 0, 0, 0, 4'h8, 5'd0, 5'd0, 5'd8); tick();
        total++; if (o_ForwardAE !== 2'b00 || o_ForwardBE !== 2'b00) begin
            bad++; $display("FAIL chain_x0: got A=%0b B=%0b expected 00/00", o_ForwardAE, o_ForwardBE); end
        drain();
        // Both M and W write x5: M wins.
        drive_d(1, 0, 0, 0, 0, 0, 4'h0, 5'd1, 5'd2, 5'd5); tick();
        drive_d(1, 0, 0, 0, 0, 0, 4'h0, 5'd3, 5'd4, 5'd5); tick();
        drive_d(1, 0, 0, 0, 0, 0, 4'h8, 5'd5, 5'd5, 5'd8); tick();
        total++; if (o_ForwardAE !== 2'b10 || o_ForwardBE !== 2'b10) begin
            bad++; $display("FAIL chain_m_priority: got A=%0b B=%0b expected 10/10", o_ForwardAE, o_ForwardBE); end
        drain();
    endtask

    task automatic test_load_use;
        drive_d(1, 2'd1, 0, 0, 0, 0, 4'h0, 5'd2, 5'd0, 5'd6); tick();
        drive_d(1, 0, 0, 0, 0, 0, 4'h0, 5'd6, 5'd1, 5'd7); #1;
        total++; if ({o_StallF, o_StallD, o_FlushE, o_FlushD} !== 4'b1110) begin
            bad++; $display("FAIL lu_stall: got SF/SD/FE/FD=%b expected 1110", {o_StallF, o_StallD, o_FlushE, o_FlushD}); end
        tick();
        total++; if ({o_StallF, o_StallD, o_FlushE} !== 3'b000) begin
            bad++; $display("FAIL lu_stall_once: got SF/SD/FE=%b expected 000", {o_StallF, o_StallD, o_FlushE}); end
        tick();
        total++; if (o_ForwardAE !== 2'b01 || o_ForwardBE !== 2'b00) begin
            bad++; $display("FAIL lu_fwd: got A=%0b B=%0b expected 01/00", o_ForwardAE, o_ForwardBE); end
        total++; if (o_ResultSrcW !== 2'd1 || o_RegWriteW !== 1'b1) begin
            bad++; $display("FAIL lu_wb: got rs=%0d rw=%0b expected 1/1", o_ResultSrcW, o_RegWriteW); end
        drain();
    endtask

    typedef struct {
        logic       valid;
        logic       jump;
        logic [2:0] bt;
        logic       z, lt, ltu;
        logic       exp;
    } br_vec_t;

    task automatic test_branch;
        br_vec_t v[12];
        v[0]  = '{1, 0, 3'b000, 1, 0, 0, 1};
        v[1]  = '{1, 0, 3'b000, 0, 1, 1, 0};
        v[2]  = '{1, 0, 3'b001, 0, 0, 0, 1};
        v[3]  = '{1, 0, 3'b001, 1, 0, 0, 0};
        v[4]  = '{1, 0, 3'b100, 0, 1, 0, 1};
        v[5]  = '{1, 0, 3'b101, 0, 1, 0, 0};
        v[6]  = '{1, 0, 3'b101, 0, 0, 1, 1};
        v[7]  = '{1, 0, 3'b110, 0, 0, 1, 1};
        v[8]  = '{1, 0, 3'b111, 0, 0, 1, 0};
        v[9]  = '{1, 0, 3'b010, 1, 1, 1, 0};
        v[10] = '{1, 1, 3'b011, 0, 0, 0, 1};
        v[11] = '{0, 0, 3'b000, 1, 0, 0, 0};
        for (int k = 0; k < 12; k++) begin
            drive_d(0, 0, 0, v[k].jump, ~v[k].jump, v[k].bt, 4'h1, 5'd1, 5'd2, 5'd0);
            i_ValidD = v[k].valid;
            tick();
            drive_d(0, 0, 1, 0, 0, 0, 4'h0, 5'd3, 5'd4, 5'd0);
            i_ZeroE = v[k].z; i_LtE = v[k].lt; i_LtuE = v[k].ltu; #1;
            total++; if ({o_PCSrcE, o_FlushD, o_FlushE} !== {3{v[k].exp}}) begin
                bad++; $display("FAIL branch_%0d: got PC/FD/FE=%b expected %b", k,
                                {o_PCSrcE, o_FlushD, o_FlushE}, {3{v[k].exp}}); end
            tick();
            clear_d();
            tick();
            total++; if (o_MemWriteM !== ~v[k].exp) begin
                bad++; $display("FAIL branch_squash_%0d: got memwrite=%0b expected %0b", k, o_MemWriteM, ~v[k].exp); end
            drain();
        end
    endtask

    task automatic test_back_to_back_hazards;
        // Jump whose own E fields also look like a load feeding D.
        drive_d(1, 2'd1, 0, 1, 0, 0, 4'h0, 5'd1, 5'd2, 5'd6); tick();
        drive_d(1, 0, 0, 0, 0, 0, 4'h0, 5'd6, 5'd1, 5'd7); #1;
        total++; if ({o_PCSrcE, o_StallF, o_FlushE, o_FlushD} !== 4'b1111) begin
            bad++; $display("FAIL simul_lw_br: got PC/SF/FE/FD=%b expected 1111", {o_PCSrcE, o_StallF, o_FlushE, o_FlushD}); end
        tick();
        clear_d(); #1;
        total++; if (o_ALUControlE !== 4'h0 || o_PCSrcE !== 1'b0) begin
            bad++; $display("FAIL simul_bubble: got alu=%0h pc=%0b expected 0/0", o_ALUControlE, o_PCSrcE); end
        drain();
    endtask

    task automatic test_mem_stall;
        drive_d(0, 0, 1, 0, 0, 0, 4'h0, 5'd2, 5'd3, 5'd0); tick();
        drive_d(0, 0, 0, 0, 1, 3'b000, 4'h1, 5'd1, 5'd2, 5'd0); tick();
        drive_d(1, 0, 1, 0, 0, 0, 4'h3, 5'd1, 5'd2, 5'd10);
        i_ZeroE = 1; i_MemStall = 1;
        for (int n = 0; n < 4; n++) begin
            #1;
            total++; if ({o_PCSrcE, o_FlushE, o_FlushD, o_StallF, o_StallD} !== 5'b10011) begin
                bad++; $display("FAIL stall_ctrl_%0d: got PC/FE/FD/SF/SD=%b expected 10011", n,
                                {o_PCSrcE, o_FlushE, o_FlushD, o_StallF, o_StallD}); end
            total++; if (o_MemWriteM !== 1'b1 || o_ALUControlE !== 4'h1) begin
                bad++; $display("FAIL stall_hold_%0d: got mw=%0b alu=%0h expected 1/1", n, o_MemWriteM, o_ALUControlE); end
            if (n < 3) tick();
        end
        i_MemStall = 0; #1;
        total++; if ({o_FlushE, o_FlushD} !== 2'b11) begin
            bad++; $display("FAIL stall_release_flush: got FE/FD=%b expected 11", {o_FlushE, o_FlushD}); end
        tick();
        clear_d(); #1;
        total++; if (o_MemWriteM !== 1'b0 || o_ALUControlE !== 4'h0 || o_PCSrcE !== 1'b0) begin
            bad++; $display("FAIL stall_resume: got mw=%0b alu=%0h pc=%0b expected 0/0/0",
                            o_MemWriteM, o_ALUControlE, o_PCSrcE); end
        drain();
    endtask

    task automatic test_reset_mid_stall;
        drive_d(1, 2'd2, 0, 0, 0, 0, 4'h5, 5'd1, 5'd2, 5'd5); tick();
        drive_d(0, 0, 1, 0, 0, 0, 4'h0, 5'd2, 5'd3, 5'd0); tick();
        drive_d(1, 0, 0, 0, 0, 0, 4'h7, 5'd5, 5'd5, 5'd9); i_ALUSrcD = 1; tick();
        total++; if ({o_RegWriteW, o_MemWriteM, o_ALUSrcE} !== 3'b111 || o_ALUControlE !== 4'h7 || o_ResultSrcW !== 2'd2) begin
            bad++; $display("FAIL rms_fill: got rw/mw/as=%b alu=%0h rs=%0d expected 111/7/2",
                            {o_RegWriteW, o_MemWriteM, o_ALUSrcE}, o_ALUControlE, o_ResultSrcW); end
        i_MemStall = 1; i_Reset = 1; tick();
        i_Reset = 0;
        total++; if ({o_RegWriteW, o_MemWriteM, o_ALUSrcE, o_PCSrcE} !== 4'b0000 || o_ALUControlE !== 4'h0 || o_ResultSrcW !== 2'd0) begin
            bad++; $display("FAIL rms_clear: got rw/mw/as/pc=%b alu=%0h rs=%0d expected 0000/0/0",
                            {o_RegWriteW, o_MemWriteM, o_ALUSrcE, o_PCSrcE}, o_ALUControlE, o_ResultSrcW); end
        total++; if (o_ForwardAE !== 2'b00 || o_ForwardBE !== 2'b00) begin
            bad++; $display("FAIL rms_fwd: got A=%0b B=%0b expected 00/00", o_ForwardAE, o_ForwardBE); end
        drain();
    endtask

    initial begin
        i_Reset = 1; i_MemStall = 0;
        clear_d();
        test_reset();
        test_alu_chain();
        test_load_use();
        test_branch();
        test_back_to_back_hazards();
        test_mem_stall();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
